// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner encodings and latched-transaction type for mem_arbiter
package mem_arb_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  typedef struct packed {
    logic        own;
    logic        wr;
    logic        flt;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational 2-way round-robin pick, req[0]=fetch, req[1]=data, one-hot gnt
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] && (!req[1] || last_winner == OWN_D);
  assign gnt[1] = req[1] && (!req[0] || last_winner == OWN_I);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin fetch/LSU arbiter sequencing one fixed-latency memory access at a time
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] rom_end     = 32'd64000,
  parameter int          mem_latency = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_fault,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_write,
  input  logic [31:0] mem_data_out
);
  localparam logic [3:0] lat = 4'(mem_latency);
  logic [1:0]  state;
  logic        last_winner;
  logic [3:0]  cnt;
  logic [1:0]  gnt;
  logic        grant;
  logic [31:0] n_addr;
  logic        n_wr;
  logic        n_flt;
  logic        resp;
  logic [31:0] rdata;
  txn_t        cur;
  rr_arbiter2 u_rr (
    .req        ({d_req, i_req}),
    .last_winner(last_winner),
    .gnt        (gnt)
  );
  assign grant  = reset && state == IDLE && |gnt;
  assign n_addr = gnt[1] ? d_addr : i_addr;
  assign n_wr   = gnt[1] && d_write;
  assign n_flt  = n_addr[1:0] != 2'b00 || (n_wr && n_addr < rom_end);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_winner <= OWN_I;
      cnt         <= '0;
      cur         <= '0;
    end else begin
      if (grant) begin
        cur         <= '{own: gnt[1], wr: n_wr, flt: n_flt, addr: n_addr, wdata: d_wdata};
        last_winner <= gnt[1];
      end
      cnt   <= grant ? lat : state == BUSY ? cnt - 4'd1 : cnt;
      state <= grant ? (n_flt ? RESP : BUSY) : state == BUSY ? (cnt == 4'd1 ? RESP : BUSY) : IDLE;
    end
  end
  assign i_gnt       = grant && !gnt[1];
  assign d_gnt       = grant && gnt[1];
  assign resp        = state == RESP;
  assign rdata       = cur.wr || cur.flt ? '0 : mem_data_out;
  assign i_rvalid    = resp && cur.own == OWN_I;
  assign i_rdata     = i_rvalid ? rdata : '0;
  assign i_fault     = i_rvalid && cur.flt;
  assign d_rvalid    = resp && cur.own == OWN_D;
  assign d_rdata     = d_rvalid ? rdata : '0;
  assign d_fault     = d_rvalid && cur.flt;
  assign mem_address = cur.addr;
  assign mem_data_in = cur.wdata;
  assign mem_write   = state == BUSY && cnt == lat && cur.wr;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam logic [31:0] rom_end = 32'd64000;
  localparam int lat = 1;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst1, i_req, d_req, d_write, i_gnt, i_rvalid, i_fault, d_gnt, d_rvalid, d_fault, mem_write;
  logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata, mem_address, mem_data_in, mem_data_out;
  logic        rst3, i_req3, d_req3, d_write3, i_gnt3, i_rvalid3, i_fault3, d_gnt3, d_rvalid3, d_fault3, mem_write3;
  logic [31:0] i_addr3, d_addr3, d_wdata3, i_rdata3, d_rdata3, mem_address3, mem_data_in3, mem_data_out3;
  mem_arbiter #(.rom_end(rom_end), .mem_latency(lat)) dut (
    .clk(clk), .reset(rst1),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_fault(i_fault),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_fault(d_fault),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write(mem_write), .mem_data_out(mem_data_out)
  );
  mem_arbiter #(.rom_end(rom_end), .mem_latency(3)) dut3 (
    .clk(clk), .reset(rst3),
    .i_req(i_req3), .i_addr(i_addr3), .i_gnt(i_gnt3), .i_rvalid(i_rvalid3), .i_rdata(i_rdata3), .i_fault(i_fault3),
    .d_req(d_req3), .d_write(d_write3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3), .d_fault(d_fault3),
    .mem_address(mem_address3), .mem_data_in(mem_data_in3), .mem_write(mem_write3), .mem_data_out(mem_data_out3)
  );
  logic [31:0] mem_arr [0:65535];
  bit          wrote [0:65535];
  logic [31:0] ref_arr [0:65535];
  bit          ref_wr [0:65535];
  logic [31:0] p3 [0:2];
  function automatic logic [31:0] dflt(input logic [31:0] x);
    return x == 32'h100 ? 32'hE3A0_0001 : {x[15:0], ~x[15:0]} ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [31:0] rref(input logic [31:0] x);
    return ref_wr[x[17:2]] ? ref_arr[x[17:2]] : dflt(x);
  endfunction
  always @(posedge clk) begin
    mem_data_out <= wrote[mem_address[17:2]] ? mem_arr[mem_address[17:2]] : dflt(mem_address);
    if (mem_write) begin
      mem_arr[mem_address[17:2]] <= mem_data_in;
      wrote[mem_address[17:2]]   <= 1'b1;
    end
  end
  always @(posedge clk) begin
    p3[0] <= dflt(mem_address3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_data_out3 = p3[2];
  int          checks = 0, fails = 0, cyc = 0, gc = 0, rc = 0, mwc = 0;
  bit          pend = 0, lw = 0, o, w, f, g_i, g_d, e_ig, e_dg, i_flt, d_flt;
  logic [31:0] a, wd, erd, i_cap, d_cap;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask
  task automatic tick();
    bit rsp;
    @(negedge clk);
    e_ig = 0;
    e_dg = 0;
    if (!pend && (i_req || d_req)) begin
      o    = d_req && (!i_req || !lw);
      lw   = o;
      e_dg = o;
      e_ig = !o;
      a    = o ? d_addr : i_addr;
      w    = o && d_write;
      wd   = d_wdata;
      f    = a[1:0] != 2'b00 || (w && a < rom_end);
      gc   = cyc;
      rc   = f ? cyc + 1 : cyc + lat + 1;
      erd  = (w || f) ? 32'd0 : rref(a);
      if (w && !f) begin
        ref_arr[a[17:2]] = wd;
        ref_wr[a[17:2]]  = 1'b1;
      end
      pend = 1;
    end
    rsp = pend && cyc == rc;
    chk("i_gnt", 32'(i_gnt), 32'(e_ig));
    chk("d_gnt", 32'(d_gnt), 32'(e_dg));
    chk("mem_write", 32'(mem_write), 32'(pend && w && !f && cyc == gc + 1));
    if (pend && w && !f && cyc == gc + 1) chk("mem_data_in", mem_data_in, wd);
    if (pend && cyc > gc) chk("mem_address", mem_address, a);
    chk("i_rvalid", 32'(i_rvalid), 32'(rsp && !o));
    chk("i_rdata", i_rdata, (rsp && !o) ? erd : 32'd0);
    chk("i_fault", 32'(i_fault), 32'(rsp && !o && f));
    chk("d_rvalid", 32'(d_rvalid), 32'(rsp && o));
    chk("d_rdata", d_rdata, (rsp && o) ? erd : 32'd0);
    chk("d_fault", 32'(d_fault), 32'(rsp && o && f));
    g_i = i_gnt;
    g_d = d_gnt;
    if (mem_write) mwc++;
    if (i_rvalid) begin
      i_cap = i_rdata;
      i_flt = i_fault;
    end
    if (d_rvalid) begin
      d_cap = d_rdata;
      d_flt = d_fault;
    end
    if (rsp) pend = 0;
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic go();
    for (int k = 0; k < 40; k++) begin
      if (!pend && !i_req && !d_req) return;
      tick();
      if (e_ig) i_req = 0;
      if (e_dg) d_req = 0;
    end
    chk("go_timeout", 32'd1, 32'd0);
  endtask
  function automatic logic [31:0] raddr();
    logic [31:0] b;
    case ($urandom % 4)
      0: b = 32'h0001_0000;
      1: b = 32'h0000_0100;
      2: b = 32'h0000_F9E0;
      default: b = 32'h0000_FA00;
    endcase
    b = b + 32'(4 * $urandom_range(0, 7));
    if ($urandom % 8 == 0) b = b + 32'($urandom_range(1, 3));
    return b;
  endfunction
  task automatic acc3(input logic [31:0] ad, input string tag);
    d_req3  = 1;
    d_addr3 = ad;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk({tag, "_gnt"}, 32'(d_gnt3), 32'(c == 0));
      chk({tag, "_rv"}, 32'(d_rvalid3), 32'(c == 4));
      if (c == 4) chk({tag, "_rd"}, d_rdata3, dflt(ad));
      if (c >= 1 && c <= 4) chk({tag, "_addr"}, mem_address3, ad);
      chk({tag, "_mw"}, 32'(mem_write3), 32'd0);
      @(posedge clk);
      #1;
      d_req3 = 0;
    end
  endtask
  initial begin
    logic [3:0] order;
    int n, rvc;
    order = '0;
    n = 0;
    rst1 = 0; rst3 = 0;
    i_req3 = 0; i_addr3 = 0; d_req3 = 0; d_write3 = 0; d_addr3 = 0; d_wdata3 = 0;
    i_req = 1; i_addr = 32'h300; d_req = 1; d_write = 0; d_addr = 32'h1_0004; d_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_i_gnt", 32'(i_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_data_in", mem_data_in, 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    @(posedge clk);
    #1;
    rst1 = 1; rst3 = 1;
    for (int k = 0; k < 40 && n < 4; k++) begin
      tick();
      if (g_i || g_d) begin
        order = {order[2:0], g_d};
        n++;
      end
    end
    i_req = 0; d_req = 0;
    go();
    chk("tie_count", 32'(n), 32'd4);
    chk("tie_order", 32'(order), 32'b1010);
    i_req = 1; i_addr = 32'h100; i_cap = 0; mwc = 0;
    go();
    chk("fetch_data", i_cap, 32'hE3A0_0001);
    chk("fetch_no_write", 32'(mwc), 32'd0);
    d_req = 1; d_write = 1; d_addr = 32'h1_0000; d_wdata = 32'hDEAD_BEEF; d_flt = 1; mwc = 0;
    go();
    chk("store_wr_pulses", 32'(mwc), 32'd1);
    chk("store_fault", 32'(d_flt), 32'd0);
    d_req = 1; d_write = 0; d_cap = 0;
    go();
    chk("load_back", d_cap, 32'hDEAD_BEEF);
    d_req = 1; d_write = 1; d_addr = 32'h40; d_flt = 0; mwc = 0;
    go();
    chk("rom_store_fault", 32'(d_flt), 32'd1);
    chk("rom_store_no_write", 32'(mwc), 32'd0);
    i_req = 1; i_addr = 32'h102; i_cap = 32'hFFFF_FFFF; i_flt = 0;
    go();
    chk("misal_fault", 32'(i_flt), 32'd1);
    chk("misal_rdata", i_cap, 32'd0);
    for (int k = 0; k < 400; k++) begin
      tick();
      if (e_ig) i_req = 0;
      if (e_dg) d_req = 0;
      if (!i_req && $urandom % 2 == 1) begin
        i_req  = 1;
        i_addr = raddr();
      end
      if (!d_req && $urandom % 2 == 1) begin
        d_req   = 1;
        d_write = 1'($urandom % 2);
        d_addr  = raddr();
        d_wdata = $urandom;
      end
    end
    i_req = 0; d_req = 0;
    go();
    acc3(32'h200, "l3a");
    d_req3 = 1; d_addr3 = 32'h204;
    @(negedge clk);
    chk("l3b_gnt", 32'(d_gnt3), 32'd1);
    @(posedge clk);
    #1;
    d_req3 = 0;
    @(posedge clk);
    #1;
    rst3 = 0;
    #1;
    chk("mid_rst_outs", 32'({d_gnt3, d_rvalid3, d_fault3, i_gnt3, i_rvalid3, i_fault3, mem_write3}), 32'd0);
    chk("mid_rst_rdata", d_rdata3 | i_rdata3, 32'd0);
    chk("mid_rst_addr", mem_address3, 32'd0);
    chk("mid_rst_din", mem_data_in3, 32'd0);
    @(posedge clk);
    #1;
    rst3 = 1;
    rvc = 0;
    repeat (6) begin
      @(negedge clk);
      if (d_rvalid3 || i_rvalid3) rvc++;
    end
    chk("mid_rst_no_rvalid", 32'(rvc), 32'd0);
    @(posedge clk);
    #1;
    acc3(32'h208, "l3c");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single `memory` port between the ARM core's instruction-fetch unit and its load/store unit. It runs a round-robin request/grant handshake and sequences each access over the memory's fixed read latency. Read data is returned to the requester that won the access. Data-side writes into the ROM region and misaligned accesses are blocked and reported as faults; they never reach the memory. The block sits between the core's fetch/LSU stages and the `memory` instance.

## Interface
- `rom_end`, 64000: first byte address of RW space; any address below it is ROM.
- `mem_latency`, 1: number of clock edges between the memory sampling `mem_address` and `mem_data_out` becoming valid; legal range 1–15.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request; held with `i_addr` stable until `i_gnt`.
- `i_addr`  in  32  fetch byte address.
- `i_gnt`  out  1  one-cycle pulse; the request is accepted.
- `i_rvalid`  out  1  one-cycle response strobe.
- `i_rdata`  out  32  fetched word; valid only with `i_rvalid`.
- `i_fault`  out  1  qualifies `i_rvalid`; set when the fetch was misaligned.
- `d_req`  in  1  data request; held with `d_write`, `d_addr` and `d_wdata` stable until `d_gnt`.
- `d_write`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_gnt`  out  1  one-cycle accept pulse.
- `d_rvalid`  out  1  one-cycle completion strobe; issued for loads and stores.
- `d_rdata`  out  32  load data; 0 for stores and faults.
- `d_fault`  out  1  qualifies `d_rvalid`; set for a store below `rom_end` or a misaligned access.
- `mem_address`  out  32  to `memory.address`.
- `mem_data_in`  out  32  to `memory.data_in`.
- `mem_write`  out  1  to `memory.write`.
- `mem_data_out`  in  32  from `memory.data_out`.

## Operation
- FSM states:
  - IDLE → BUSY when there is a request and no fault.
  - IDLE → RESP when there is a faulting request.
  - BUSY → RESP after `mem_latency` cycles.
  - RESP → IDLE always.
- Arbitration happens in IDLE only, combinationally.
  - A single requester wins.
  - If both request, the winner is the one that did not win last; this is a 1-bit `last_winner` register.
  - A `gnt` pulse is raised in the same cycle as the win.
- On the grant edge the block latches the owner, address, write flag and wdata, and loads the latency counter with `mem_latency`.
- Fault check at grant (owner, address, write flag are as latched on the grant edge):
  - `addr[1:0] != 0`: fault.
  - Data store with `addr < rom_end` (unsigned compare): fault.
  - Loads from ROM are legal.
- BUSY:
  - `mem_address` is driven with the latched address; it is held through BUSY and RESP.
  - `mem_write` = latched write flag, during the first BUSY cycle only.
  - The counter decrements every cycle; leave BUSY when it reaches 1.
- RESP:
  - The owner's `rvalid` = 1.
  - Owner `rdata` = `mem_data_out` (passthrough) for loads and fetches; 0 for stores and faults.
  - The owner's fault flag reflects the latched fault.
- Only one transaction is outstanding at a time. A request that is asserted during BUSY or RESP waits in IDLE for arbitration.
- Outside RESP, `rvalid`, `rdata` and `fault` for both requesters are 0. The non-owner's response outputs are always 0.

## Timing
- Reset (asynchronous, active-low):
  - State → IDLE.
  - `last_winner` → fetch, so data wins the first tie.
  - Counter → 0.
  - `mem_address`, `mem_data_in`, `mem_write`, every `gnt`, `rvalid`, `rdata` and `fault` → 0.
- Reset mid-BUSY aborts the access. A `mem_write` pulse already issued is not undone. No `rvalid` is issued.
- Normal access: grant in cycle N, BUSY during N+1 … N+`mem_latency`, RESP in N+`mem_latency`+1. With the default latency this is 3 cycles per access.
- Faulting access: grant in N, RESP in N+1, no memory cycle.
- The earliest next grant is the cycle after RESP. A requester whose `req` stays high wins that cycle if the other requester is idle.
- `mem_write` is never high outside the first BUSY cycle and never high for a fetch.

## Structure
- Shared package `mem_arb_pkg`:
  - State encoding: IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2.
  - Owner encoding: OWN_I = 1'b0, OWN_D = 1'b1.
- Sub-module `rr_arbiter2`: 2-way round-robin pick from `req[1:0]` and `last_winner`, producing a one-hot `gnt`. It is combinational; the `last_winner` register lives in the parent.
- The FSM, latches and counter live in `mem_arbiter`.

## Test plan
- Reset, then fetch only, `i_addr` = 0x100, memory model returns 0xE3A00001: `i_gnt` in cycle 0; `mem_address` = 0x100 in cycle 1; `i_rvalid` = 1 with `i_rdata` = 0xE3A00001 in cycle 2; `mem_write` = 0 throughout.
- `i_req` and `d_req` both raised in the first cycle after reset: data wins first, then fetch; with both held high, the grants alternate D, I, D, I.
- Store `d_addr` = 0x10000 (≥ 64000), `d_wdata` = 0xDEADBEEF: `mem_write` = 1 for exactly one cycle (cycle 1) with `mem_data_in` = 0xDEADBEEF; `d_rvalid` = 1 with `d_fault` = 0 in cycle 2; a following load of 0x10000 returns 0xDEADBEEF.
- Store `d_addr` = 0x40: `d_gnt` in cycle 0; `d_rvalid` and `d_fault` = 1 in cycle 1; `mem_write` never asserted.
- Fetch `i_addr` = 0x102: `i_fault` = 1 with `i_rvalid` in cycle 1; `i_rdata` = 0.
- `mem_latency` = 3, load from 0x200: RESP in cycle 4. Assert `reset` low during cycle 2 of a second access: no `rvalid`, all outputs 0, the next access proceeds normally.
